// File: rtl/dma_priority_arbiter_pkg.sv
// Shared types and constants for the DMA request/priority stage.
// Holds the arbiter state encoding and the command-register bit positions.
package DmaPackage;

  localparam int NCH = 4;

  localparam int CMD_DISABLE   = 2;
  localparam int CMD_ROTATE    = 4;
  localparam int CMD_DREQ_LOW  = 6;
  localparam int CMD_DACK_HIGH = 7;

  typedef enum logic [3:0] {
    ARB_IDLE    = 4'b0001,
    ARB_REQ     = 4'b0010,
    ARB_GRANT   = 4'b0100,
    ARB_RELEASE = 4'b1000
  } arb_state_t;

  function automatic logic [NCH-1:0] chOneHot(input logic [1:0] ch);
    logic [NCH-1:0] vec;
    vec = '0;
    vec[ch] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/dma_prio_encoder.sv
// Rotating find-first: rotates pend so hiPtr sits at bit 0, picks the lowest
// set bit, then rotates the index back into channel numbering.
module dma_prio_encoder (
  input  logic [3:0] pend,
  input  logic [1:0] hiPtr,
  output logic [1:0] win,
  output logic       anyReq
);

  logic [3:0] rotated;
  logic [1:0] offset;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gRot
      assign rotated[gi] = pend[2'(gi) + hiPtr];
    end
  endgenerate

  always_comb begin
    offset = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rotated[i]) offset = 2'(i);
    end
  end

  // 2-bit addition wraps modulo 4, which is the rotate-back.
  assign win    = offset + hiPtr;
  assign anyReq = |pend;

endmodule

// File: rtl/dma_priority_arbiter.sv
// DREQ conditioning and fixed/rotating priority arbitration for the DMA timing FSM.
// One channel is latched per service and held until EOP or the FSM returns to idle.
module dma_priority_arbiter #(
  parameter int NCH         = DmaPackage::NCH,
  parameter int SYNC_STAGES = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [NCH-1:0] DREQ,
  input  logic [7:0]     command_reg,
  input  logic [NCH-1:0] mask_reg,
  input  logic [NCH-1:0] request_reg,
  input  logic           idle_cycle,
  input  logic           valid_dack,
  input  logic           eop_n,
  output logic [NCH-1:0] valid_dreq,
  output logic [NCH-1:0] DACK,
  output logic [1:0]     active_ch,
  output logic           channel_active,
  output logic [NCH-1:0] dreq_status,
  output logic [NCH-1:0] sw_req_clr
);

  import DmaPackage::*;

  arb_state_t     stateReg;
  logic [1:0]     hiPtrReg;
  logic [1:0]     winReg;
  logic [1:0]     activeChReg;
  logic           channelActiveReg;
  logic [NCH-1:0] validDreqReg;
  logic [NCH-1:0] dreqStatusReg;
  logic [NCH-1:0] swReqClrReg;
  logic           idlePrevReg;
  logic           eopSeenReg;

  logic [NCH-1:0] dreqSync;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] grantVec;
  logic [1:0]     hiPtrEff;
  logic [1:0]     encWin;
  logic           encAny;
  logic           idleRise;
  logic           unusedCmd;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : gSync
      logic [NCH-1:0] stageReg;
      if (gi == 0) begin : gFirst
        always_ff @(posedge CLK or posedge RESET) begin
          if (RESET) stageReg <= '0;
          else       stageReg <= DREQ;
        end
      end else begin : gNext
        always_ff @(posedge CLK or posedge RESET) begin
          if (RESET) stageReg <= '0;
          else       stageReg <= gSync[gi-1].stageReg;
        end
      end
    end
  endgenerate

  assign dreqSync = gSync[SYNC_STAGES-1].stageReg;

  // Software requests bypass polarity and mask.
  assign pend     = ((dreqSync ^ {NCH{command_reg[CMD_DREQ_LOW]}}) & ~mask_reg) | request_reg;
  assign hiPtrEff = command_reg[CMD_ROTATE] ? hiPtrReg : 2'd0;
  assign idleRise = idle_cycle & ~idlePrevReg;

  // Memory-to-memory and the remaining command bits belong to other blocks.
  assign unusedCmd = ^{command_reg[5], command_reg[3], command_reg[1:0]};

  dma_prio_encoder uEncoder (
    .pend   (pend),
    .hiPtr  (hiPtrEff),
    .win    (encWin),
    .anyReq (encAny)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stateReg         <= ARB_IDLE;
      hiPtrReg         <= 2'd0;
      winReg           <= 2'd0;
      activeChReg      <= 2'd0;
      channelActiveReg <= 1'b0;
      validDreqReg     <= '0;
      dreqStatusReg    <= '0;
      swReqClrReg      <= '0;
      idlePrevReg      <= 1'b0;
      eopSeenReg       <= 1'b0;
    end else begin
      idlePrevReg   <= idle_cycle;
      dreqStatusReg <= pend;
      swReqClrReg   <= '0;
      case (stateReg)
        ARB_IDLE: begin
          if (idle_cycle && !command_reg[CMD_DISABLE] && encAny) begin
            winReg       <= encWin;
            validDreqReg <= chOneHot(encWin);
            stateReg     <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (valid_dack) begin
            // An EOP coinciding with the acknowledge still lets the grant happen once.
            stateReg         <= ARB_GRANT;
            channelActiveReg <= 1'b1;
            activeChReg      <= winReg;
            eopSeenReg       <= ~eop_n;
          end else if (!pend[winReg]) begin
            validDreqReg <= '0;
            stateReg     <= ARB_IDLE;
          end
        end
        ARB_GRANT: begin
          if (!eop_n || eopSeenReg || idleRise) begin
            stateReg         <= ARB_RELEASE;
            validDreqReg     <= '0;
            channelActiveReg <= 1'b0;
            hiPtrReg         <= command_reg[CMD_ROTATE] ? winReg + 2'd1 : 2'd0;
            if ((!eop_n || eopSeenReg) && request_reg[winReg]) begin
              swReqClrReg <= chOneHot(winReg);
            end
          end
        end
        ARB_RELEASE: begin
          eopSeenReg <= 1'b0;
          stateReg   <= ARB_IDLE;
        end
        default: begin
          stateReg <= ARB_IDLE;
        end
      endcase
    end
  end

  // Combinational from the registered grant so an async reset drops DACK at once.
  assign grantVec = channelActiveReg ? chOneHot(activeChReg) : '0;
  assign DACK     = command_reg[CMD_DACK_HIGH] ? grantVec : ~grantVec;

  assign valid_dreq     = validDreqReg;
  assign active_ch      = activeChReg;
  assign channel_active = channelActiveReg;
  assign dreq_status    = dreqStatusReg;
  assign sw_req_clr     = swReqClrReg;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Scenario bench for dma_priority_arbiter: directed cases plus randomized services
// checked against a search-order reference model.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic [7:0] command_reg;
  logic [3:0] mask_reg;
  logic [3:0] request_reg;
  logic       idle_cycle;
  logic       valid_dack;
  logic       eop_n;
  logic [3:0] valid_dreq;
  logic [3:0] DACK;
  logic [1:0] active_ch;
  logic       channel_active;
  logic [3:0] dreq_status;
  logic [3:0] sw_req_clr;

  int checks = 0;
  int errors = 0;
  logic [1:0] modelPtr = 2'd0;

  dma_priority_arbiter dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .DREQ           (DREQ),
    .command_reg    (command_reg),
    .mask_reg       (mask_reg),
    .request_reg    (request_reg),
    .idle_cycle     (idle_cycle),
    .valid_dack     (valid_dack),
    .eop_n          (eop_n),
    .valid_dreq     (valid_dreq),
    .DACK           (DACK),
    .active_ch      (active_ch),
    .channel_active (channel_active),
    .dreq_status    (dreq_status),
    .sw_req_clr     (sw_req_clr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Reference model: a channel is pending if its pin is at the asserted level and
  // unmasked, or if software requests it.
  function automatic logic [3:0] modelPend(input logic [3:0] dreq, input logic [7:0] cmd,
                                           input logic [3:0] mask, input logic [3:0] req);
    logic [3:0] p;
    p = '0;
    for (int c = 0; c < 4; c++) begin
      bit asserted;
      asserted = cmd[6] ? (dreq[c] == 1'b0) : (dreq[c] == 1'b1);
      if ((asserted && !mask[c]) || req[c]) p[c] = 1'b1;
    end
    return p;
  endfunction

  function automatic int modelWinner(input logic [3:0] p, input int start);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (start + k) % 4;
      if (p[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] bitOf(input int c);
    return 4'(1 << c);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input int maxCyc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= maxCyc; i++) begin
      tick();
      if (valid_dreq != 4'b0000) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Acknowledge the pending request, observe the grant, then end it by EOP or idle return.
  task automatic serve(input bit useEop, output logic [1:0] gCh, output logic [3:0] gDack,
                       output logic gAct, output logic [3:0] rClr, output logic [3:0] rDack,
                       output logic rAct);
    valid_dack = 1'b1;
    idle_cycle = 1'b0;
    tick();
    gCh = active_ch; gDack = DACK; gAct = channel_active;
    valid_dack = 1'b0;
    if (useEop) eop_n = 1'b0;
    else        idle_cycle = 1'b1;
    tick();
    rClr = sw_req_clr; rDack = DACK; rAct = channel_active;
    eop_n = 1'b1;
    idle_cycle = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if (valid_dreq !== 4'b0000 || channel_active !== 1'b0 || active_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got vd=%b ca=%b ac=%0d required vd=0000 ca=0 ac=0", valid_dreq, channel_active, active_ch);
    end
    checks++;
    if (DACK !== 4'hF) begin
      errors++;
      $display("FAIL reset_dack: got %b required 1111", DACK);
    end
    checks++;
    if (dreq_status !== 4'b0000 || sw_req_clr !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status: got st=%b clr=%b required 0000/0000", dreq_status, sw_req_clr);
    end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_fixed();
    command_reg = 8'h00;
    DREQ = 4'b1010;
    repeat (2) tick();
    checks++;
    if (valid_dreq !== 4'b0000) begin
      errors++;
      $display("FAIL fixed_latency_early: got %b required 0000 after 2 edges", valid_dreq);
    end
    tick();
    checks++;
    if (valid_dreq !== bitOf(modelWinner(modelPend(DREQ, command_reg, mask_reg, request_reg), 0))) begin
      errors++;
      $display("FAIL fixed_valid: got %b required 0010", valid_dreq);
    end
    valid_dack = 1'b1;
    idle_cycle = 1'b0;
    tick();
    checks++;
    if (DACK !== 4'b1101 || active_ch !== 2'd1 || channel_active !== 1'b1) begin
      errors++;
      $display("FAIL fixed_grant: got dack=%b ac=%0d ca=%b required 1101/1/1", DACK, active_ch, channel_active);
    end
    valid_dack = 1'b0;
    eop_n = 1'b0;
    DREQ = 4'b0000;
    tick();
    checks++;
    if (DACK !== 4'hF || channel_active !== 1'b0 || valid_dreq !== 4'b0000) begin
      errors++;
      $display("FAIL fixed_release: got dack=%b ca=%b vd=%b required 1111/0/0000", DACK, channel_active, valid_dreq);
    end
    eop_n = 1'b1;
    idle_cycle = 1'b1;
    modelPtr = 2'd0;
    repeat (4) tick();
  endtask

  task automatic test_rotating();
    int cyc;
    int expW;
    logic [1:0] gCh; logic [3:0] gDack; logic gAct; logic [3:0] rClr; logic [3:0] rDack; logic rAct;
    command_reg = 8'h10;
    DREQ = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      wait_valid(6, cyc);
      expW = modelWinner(4'b1111, int'(modelPtr));
      checks++;
      if (cyc < 0 || valid_dreq !== bitOf(expW)) begin
        errors++;
        $display("FAIL rotate_valid[%0d]: got %b required %b", s, valid_dreq, bitOf(expW));
      end
      serve(1'b1, gCh, gDack, gAct, rClr, rDack, rAct);
      checks++;
      if (gCh !== 2'(expW) || gDack !== ~bitOf(expW) || gAct !== 1'b1) begin
        errors++;
        $display("FAIL rotate_grant[%0d]: got ch=%0d dack=%b required ch=%0d dack=%b", s, gCh, gDack, expW, ~bitOf(expW));
      end
      modelPtr = 2'(expW + 1);
    end
    checks++;
    if (dreq_status !== 4'b1111) begin
      errors++;
      $display("FAIL rotate_status: got %b required 1111", dreq_status);
    end
    DREQ = 4'b0000;
    repeat (6) tick();
  endtask

  task automatic test_polarity();
    int cyc;
    logic [1:0] gCh; logic [3:0] gDack; logic gAct; logic [3:0] rClr; logic [3:0] rDack; logic rAct;
    mask_reg = 4'hF;
    DREQ = 4'hF;
    command_reg = 8'hC0;
    repeat (3) tick();
    mask_reg = 4'h0;
    DREQ = 4'b1110;
    tick();
    checks++;
    if (DACK !== 4'b0000) begin
      errors++;
      $display("FAIL polarity_idle_dack: got %b required 0000", DACK);
    end
    wait_valid(6, cyc);
    checks++;
    if (cyc < 0 || valid_dreq !== 4'b0001) begin
      errors++;
      $display("FAIL polarity_valid: got %b required 0001", valid_dreq);
    end
    serve(1'b1, gCh, gDack, gAct, rClr, rDack, rAct);
    checks++;
    if (gDack !== 4'b0001 || rDack !== 4'b0000) begin
      errors++;
      $display("FAIL polarity_dack: got grant=%b release=%b required 0001/0000", gDack, rDack);
    end
    modelPtr = 2'd0;
    mask_reg = 4'hF;
    DREQ = 4'h0;
    command_reg = 8'h00;
    repeat (4) tick();
    mask_reg = 4'h0;
    tick();
  endtask

  task automatic test_sw_req();
    logic [1:0] gCh; logic [3:0] gDack; logic gAct; logic [3:0] rClr; logic [3:0] rDack; logic rAct;
    command_reg = 8'h00;
    mask_reg = 4'hF;
    DREQ = 4'hF;
    request_reg = 4'b0100;
    tick();
    checks++;
    if (valid_dreq !== 4'b0100) begin
      errors++;
      $display("FAIL swreq_valid: got %b required 0100", valid_dreq);
    end
    serve(1'b1, gCh, gDack, gAct, rClr, rDack, rAct);
    request_reg = 4'b0000;
    checks++;
    if (rClr !== 4'b0100) begin
      errors++;
      $display("FAIL swreq_clr: got %b required 0100", rClr);
    end
    checks++;
    if (sw_req_clr !== 4'b0000) begin
      errors++;
      $display("FAIL swreq_clr_width: got %b required 0000 one cycle later", sw_req_clr);
    end
    request_reg = 4'b0001;
    tick();
    serve(1'b0, gCh, gDack, gAct, rClr, rDack, rAct);
    request_reg = 4'b0000;
    checks++;
    if (rClr !== 4'b0000 || rAct !== 1'b0) begin
      errors++;
      $display("FAIL swreq_idle_release: got clr=%b ca=%b required 0000/0", rClr, rAct);
    end
    modelPtr = 2'd0;
    DREQ = 4'h0;
    repeat (3) tick();
    mask_reg = 4'h0;
  endtask

  task automatic test_withdraw();
    int cyc;
    DREQ = 4'b1000;
    wait_valid(6, cyc);
    checks++;
    if (cyc < 0 || valid_dreq !== 4'b1000) begin
      errors++;
      $display("FAIL withdraw_first: got %b required 1000", valid_dreq);
    end
    DREQ = 4'b1001;
    repeat (4) tick();
    checks++;
    if (valid_dreq !== 4'b1000) begin
      errors++;
      $display("FAIL no_preempt: got %b required 1000", valid_dreq);
    end
    DREQ = 4'b0001;
    for (int i = 0; i < 6 && valid_dreq === 4'b1000; i++) tick();
    checks++;
    if (valid_dreq !== 4'b0000) begin
      errors++;
      $display("FAIL withdraw_drop: got %b required 0000", valid_dreq);
    end
    tick();
    checks++;
    if (valid_dreq !== 4'b0001) begin
      errors++;
      $display("FAIL withdraw_rearb: got %b required 0001", valid_dreq);
    end
    DREQ = 4'b0000;
    for (int i = 0; i < 6 && valid_dreq !== 4'b0000; i++) tick();
    checks++;
    if (valid_dreq !== 4'b0000 || channel_active !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_idle: got vd=%b ca=%b required 0000/0", valid_dreq, channel_active);
    end
    repeat (2) tick();
  endtask

  task automatic test_disable();
    int cyc;
    bit sawValid;
    logic [1:0] gCh; logic [3:0] gDack; logic gAct; logic [3:0] rClr; logic [3:0] rDack; logic rAct;
    DREQ = 4'b0010;
    wait_valid(6, cyc);
    valid_dack = 1'b1;
    idle_cycle = 1'b0;
    tick();
    command_reg = 8'h04;
    valid_dack = 1'b0;
    repeat (2) tick();
    checks++;
    if (channel_active !== 1'b1 || DACK !== 4'b1101) begin
      errors++;
      $display("FAIL disable_grant_holds: got ca=%b dack=%b required 1/1101", channel_active, DACK);
    end
    eop_n = 1'b0;
    tick();
    eop_n = 1'b1;
    idle_cycle = 1'b1;
    checks++;
    if (channel_active !== 1'b0) begin
      errors++;
      $display("FAIL disable_grant_ends: got ca=%b required 0", channel_active);
    end
    sawValid = 1'b0;
    repeat (8) begin
      tick();
      if (valid_dreq !== 4'b0000) sawValid = 1'b1;
    end
    checks++;
    if (sawValid) begin
      errors++;
      $display("FAIL disable_blocks: got a valid_dreq while disabled, required none");
    end
    command_reg = 8'h00;
    wait_valid(4, cyc);
    checks++;
    if (cyc < 0 || valid_dreq !== 4'b0010) begin
      errors++;
      $display("FAIL disable_resume: got %b required 0010", valid_dreq);
    end
    serve(1'b1, gCh, gDack, gAct, rClr, rDack, rAct);
    modelPtr = 2'd0;
    DREQ = 4'b0000;
    repeat (6) tick();
  endtask

  task automatic test_simultaneous();
    int cyc;
    DREQ = 4'b0100;
    wait_valid(6, cyc);
    eop_n = 1'b0;
    tick();
    checks++;
    if (valid_dreq !== 4'b0100 || channel_active !== 1'b0) begin
      errors++;
      $display("FAIL eop_in_req: got vd=%b ca=%b required 0100/0", valid_dreq, channel_active);
    end
    valid_dack = 1'b1;
    idle_cycle = 1'b0;
    tick();
    checks++;
    if (channel_active !== 1'b1 || DACK !== 4'b1011) begin
      errors++;
      $display("FAIL eop_with_dack_grant: got ca=%b dack=%b required 1/1011", channel_active, DACK);
    end
    valid_dack = 1'b0;
    eop_n = 1'b1;
    tick();
    checks++;
    if (channel_active !== 1'b0 || DACK !== 4'hF) begin
      errors++;
      $display("FAIL eop_with_dack_release: got ca=%b dack=%b required 0/1111", channel_active, DACK);
    end
    idle_cycle = 1'b1;
    modelPtr = 2'd0;
    DREQ = 4'b0000;
    repeat (6) tick();
  endtask

  task automatic test_async_reset();
    int cyc;
    bit sawClr;
    request_reg = 4'b0001;
    wait_valid(3, cyc);
    valid_dack = 1'b1;
    idle_cycle = 1'b0;
    tick();
    checks++;
    if (DACK !== 4'b1110) begin
      errors++;
      $display("FAIL areset_pre: got %b required 1110", DACK);
    end
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if (DACK !== 4'hF || channel_active !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: got dack=%b ca=%b required 1111/0", DACK, channel_active);
    end
    valid_dack = 1'b0;
    eop_n = 1'b0;
    sawClr = 1'b0;
    repeat (2) begin
      tick();
      if (sw_req_clr !== 4'b0000) sawClr = 1'b1;
    end
    checks++;
    if (sawClr) begin
      errors++;
      $display("FAIL areset_no_clr: got a sw_req_clr pulse, required none");
    end
    request_reg = 4'b0000;
    eop_n = 1'b1;
    idle_cycle = 1'b1;
    RESET = 1'b0;
    modelPtr = 2'd0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    logic [7:0] cmdv;
    logic [3:0] expP;
    logic [3:0] expClr;
    int w;
    bit useEop;
    logic [1:0] gCh; logic [3:0] gDack; logic gAct; logic [3:0] rClr; logic [3:0] rDack; logic rAct;
    for (int it = 0; it < 40; it++) begin
      idle_cycle = 1'b0;
      cmdv = 8'h00;
      cmdv[0] = 1'($urandom_range(0, 1));
      cmdv[4] = 1'($urandom_range(0, 1));
      cmdv[6] = 1'($urandom_range(0, 1));
      cmdv[7] = 1'($urandom_range(0, 1));
      command_reg = cmdv;
      DREQ = 4'($urandom);
      mask_reg = 4'($urandom);
      request_reg = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
      expP = modelPend(DREQ, cmdv, mask_reg, request_reg);
      if (expP == 4'b0000) begin
        request_reg = bitOf($urandom_range(0, 3));
        expP = modelPend(DREQ, cmdv, mask_reg, request_reg);
      end
      repeat (3) tick();
      checks++;
      if (dreq_status !== expP || DACK !== (cmdv[7] ? 4'h0 : 4'hF)) begin
        errors++;
        $display("FAIL rand_status[%0d]: got st=%b dack=%b required st=%b", it, dreq_status, DACK, expP);
      end
      idle_cycle = 1'b1;
      tick();
      w = modelWinner(expP, cmdv[4] ? int'(modelPtr) : 0);
      checks++;
      if (valid_dreq !== bitOf(w)) begin
        errors++;
        $display("FAIL rand_valid[%0d]: got %b required %b (pend=%b ptr=%0d)", it, valid_dreq, bitOf(w), expP, modelPtr);
      end
      useEop = 1'($urandom_range(0, 1));
      expClr = (useEop && request_reg[w]) ? bitOf(w) : 4'b0000;
      serve(useEop, gCh, gDack, gAct, rClr, rDack, rAct);
      checks++;
      if (gCh !== 2'(w) || gDack !== (cmdv[7] ? bitOf(w) : ~bitOf(w)) || rClr !== expClr || rAct !== 1'b0) begin
        errors++;
        $display("FAIL rand_service[%0d]: got ch=%0d dack=%b clr=%b required ch=%0d clr=%b", it, gCh, gDack, rClr, w, expClr);
      end
      modelPtr = cmdv[4] ? 2'(w + 1) : 2'd0;
      idle_cycle = 1'b0;
    end
    request_reg = 4'b0000;
    mask_reg = 4'hF;
    command_reg = 8'h00;
    DREQ = 4'h0;
    repeat (3) tick();
  endtask

  initial begin
    RESET = 1'b1;
    DREQ = 4'h0;
    command_reg = 8'h00;
    mask_reg = 4'h0;
    request_reg = 4'h0;
    idle_cycle = 1'b1;
    valid_dack = 1'b0;
    eop_n = 1'b1;
    test_reset();
    test_fixed();
    test_rotating();
    test_polarity();
    test_sw_req();
    test_withdraw();
    test_disable();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
